// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READ = 2'd2} state_t;

  typedef struct packed {
    logic clr;
    logic ld;
    logic sh_out;
    logic sh_in;
  } serdes_ctl_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits carried by the last word of a chain of len bits.
  function automatic int final_bits(input int len, input int w);
    return ((len % w) == 0) ? w : (len % w);
  endfunction
endpackage

// File: rtl/ccff_word_serdes.sv
// Word shift register: parallel load + LSB-first shift out, or indexed bit capture.
module ccff_word_serdes import ccff_loader_pkg::*; #(
  parameter int WORD_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         ld,
  input  logic [WORD_W-1:0]            ld_data,
  input  logic [cnt_w(WORD_W)-1:0]     ld_cnt,
  input  logic                         sh_out,
  input  logic                         sh_in,
  input  logic                         din,
  output logic [WORD_W-1:0]            data,
  output logic [WORD_W-1:0]            ins_data,
  output logic [cnt_w(WORD_W)-1:0]     cnt
);
  localparam int CW = cnt_w(WORD_W);

  // Word as it would look with din written at the next free position.
  always_comb begin
    ins_data = data;
    for (int i = 0; i < WORD_W; i++)
      if (CW'(i) == cnt) ins_data[i] = din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (ld) begin
      data <= ld_data;
      cnt  <= ld_cnt;
    end else if (sh_out) begin
      data <= data >> 1;
      cnt  <= cnt - 1'b1;
    end else if (sh_in) begin
      data <= ins_data;
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises bitstream words into the chain head and
// reads the chain back non-destructively by recirculating tail into head.
module ccff_bitstream_loader import ccff_loader_pkg::*; #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start_load,
  input  logic              start_readback,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW  = cnt_w(CHAIN_LEN);
  localparam int SCW = cnt_w(WORD_W);
  localparam logic [CW-1:0]  LEN    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  LEN_M1 = CW'(CHAIN_LEN - 1);
  localparam logic [SCW-1:0] W_FULL = SCW'(WORD_W);
  localparam logic [SCW-1:0] W_M1   = SCW'(WORD_W - 1);
  localparam logic [SCW-1:0] FB_M1  = SCW'(final_bits(CHAIN_LEN, WORD_W) - 1);

  state_t state, state_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt, acc_cnt, acc_cnt_nxt;
  logic              head_nxt, sen_nxt, done_nxt, err_nxt, m_valid_nxt;
  logic [WORD_W-1:0] m_data_nxt, ser_data, ins_data;
  logic [SCW-1:0]    ser_cnt, ld_cnt;
  logic              hold_free, pend, complete, last_acc;
  serdes_ctl_t       ctl;

  ccff_word_serdes #(.WORD_W(WORD_W)) u_serdes (
    .clk(prog_clk), .rst(prog_reset), .clr(ctl.clr), .ld(ctl.ld),
    .ld_data(s_data >> 1), .ld_cnt(ld_cnt), .sh_out(ctl.sh_out), .sh_in(ctl.sh_in),
    .din(ccff_tail), .data(ser_data), .ins_data(ins_data), .cnt(ser_cnt)
  );

  assign busy      = (state != IDLE);
  assign s_ready   = (state == LOAD) && (ser_cnt == '0) && (acc_cnt < LEN);
  assign last_acc  = (int'(acc_cnt) + WORD_W >= CHAIN_LEN);
  // Bit 0 goes straight to the head register, so the serdes keeps nbits-1.
  assign ld_cnt    = last_acc ? FB_M1 : W_M1;
  assign hold_free = !m_valid || m_ready;
  assign pend      = (ser_cnt == W_FULL) || ((ser_cnt != '0) && (bit_cnt == LEN));
  assign complete  = (ser_cnt == W_M1) || (bit_cnt == LEN_M1);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      bit_cnt       <= '0;
      acc_cnt       <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
    end else begin
      bit_cnt       <= bit_cnt_nxt;
      acc_cnt       <= acc_cnt_nxt;
      ccff_head     <= head_nxt;
      ccff_shift_en <= sen_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      m_valid       <= m_valid_nxt;
      m_data        <= m_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt + CW'(ccff_shift_en);
    acc_cnt_nxt = acc_cnt;
    head_nxt    = 1'b0;
    sen_nxt     = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = err;
    m_valid_nxt = m_valid && !m_ready;
    m_data_nxt  = m_data;
    ctl         = '0;
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      err_nxt     = 1'b1;
      m_valid_nxt = 1'b0;
      ctl.clr     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_load || start_readback) begin
            state_nxt   = start_load ? LOAD : READ;
            bit_cnt_nxt = '0;
            acc_cnt_nxt = '0;
            err_nxt     = 1'b0;
            ctl.clr     = 1'b1;
          end
        end
        LOAD: begin
          if (ccff_shift_en && bit_cnt == LEN_M1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (ser_cnt != '0) begin
            head_nxt   = ser_data[0];
            sen_nxt    = 1'b1;
            ctl.sh_out = 1'b1;
          end else if (s_valid && s_ready) begin
            head_nxt    = s_data[0];
            sen_nxt     = 1'b1;
            ctl.ld      = 1'b1;
            acc_cnt_nxt = acc_cnt + CW'(ld_cnt) + 1'b1;
          end
        end
        READ: begin
          // Head is registered, so each bit takes a sample cycle (head <= tail)
          // followed by the shift cycle in which head equals the stable tail.
          if (ccff_shift_en) begin
            if (complete && hold_free) begin
              m_data_nxt  = ins_data;
              m_valid_nxt = 1'b1;
              ctl.clr     = 1'b1;
            end else begin
              ctl.sh_in = 1'b1;
            end
          end else begin
            if (pend && hold_free) begin
              m_data_nxt  = ser_data;
              m_valid_nxt = 1'b1;
              ctl.clr     = 1'b1;
            end
            if (bit_cnt != LEN && (!pend || hold_free)) begin
              head_nxt = ccff_tail;
              sen_nxt  = 1'b1;
            end
            if (m_valid && m_ready && bit_cnt == LEN && ser_cnt == '0) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule
